// File: rtl/modexp_sequencer.sv
// modexp_sequencer: drives a pipelined 256-bit modular multiplier to compute
// base^exp mod p by left-to-right binary square-and-multiply, one multiply in flight.
module modexp_sequencer #(
    parameter int unsigned EXP_BITS = 256,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned CNT_W    = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [255:0]        base,
    input  logic [EXP_BITS-1:0] exp,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [255:0]        result,
    output logic [CNT_W-1:0]    op_count,
    output logic                mul_in_valid,
    output logic [255:0]        mul_x,
    output logic [255:0]        mul_y,
    input  logic [255:0]        mul_q,
    input  logic                mul_out_valid
);

    localparam int unsigned IdxW  = (EXP_BITS > 1) ? $clog2(EXP_BITS) : 1;
    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StSqrIssue,
        StSqrWait,
        StMulIssue,
        StMulWait,
        StDone
    } state_e;

    state_e              state_q;
    logic [255:0]        b_q;
    logic [255:0]        acc_q;
    logic [EXP_BITS-1:0] e_q;
    logic [IdxW-1:0]     idx_q;
    logic [WaitW-1:0]    wait_q;
    logic                bit_set;
    logic                idx_zero;
    logic                wait_expired;

    // Current exponent bit and loop-end / timeout conditions.
    always_comb begin
        bit_set      = e_q[idx_q];
        idx_zero     = (idx_q == '0);
        // The issue cycle counts towards the budget, so done lands TIMEOUT cycles after issue.
        wait_expired = (wait_q == WaitW'(TIMEOUT - 2));
    end

    // Sequencer FSM; all outputs are registered and set on entry to the state that owns them.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            b_q          <= '0;
            acc_q        <= '0;
            e_q          <= '0;
            idx_q        <= '0;
            wait_q       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            result       <= '0;
            op_count     <= '0;
            mul_in_valid <= 1'b0;
            mul_x        <= '0;
            mul_y        <= '0;
        end else begin
            mul_in_valid <= 1'b0;
            done         <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        b_q      <= base;
                        e_q      <= exp;
                        op_count <= '0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        if (exp == '0) begin
                            acc_q   <= 256'd1;
                            result  <= 256'd1;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q   <= IdxW'(EXP_BITS - 1);
                            state_q <= StScan;
                        end
                    end
                end
                StScan: begin
                    if (bit_set) begin
                        acc_q <= b_q;
                        if (idx_zero) begin
                            result  <= b_q;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q        <= idx_q - IdxW'(1);
                            mul_x        <= b_q;
                            mul_y        <= b_q;
                            mul_in_valid <= 1'b1;
                            state_q      <= StSqrIssue;
                        end
                    end else begin
                        idx_q <= idx_q - IdxW'(1);
                    end
                end
                StSqrIssue, StMulIssue: begin
                    if (op_count != '1) begin
                        op_count <= op_count + CNT_W'(1);
                    end
                    wait_q  <= '0;
                    state_q <= (state_q == StSqrIssue) ? StSqrWait : StMulWait;
                end
                StSqrWait, StMulWait: begin
                    if (mul_out_valid) begin
                        acc_q <= mul_q;
                        if ((state_q == StSqrWait) && bit_set) begin
                            mul_x        <= mul_q;
                            mul_y        <= b_q;
                            mul_in_valid <= 1'b1;
                            state_q      <= StMulIssue;
                        end else if (idx_zero) begin
                            result  <= mul_q;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q        <= idx_q - IdxW'(1);
                            mul_x        <= mul_q;
                            mul_y        <= mul_q;
                            mul_in_valid <= 1'b1;
                            state_q      <= StSqrIssue;
                        end
                    end else if (wait_expired) begin
                        acc_q   <= '0;
                        result  <= '0;
                        error   <= 1'b1;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        wait_q <= wait_q + WaitW'(1);
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
